// File: rtl/prescaled_counter.sv
// prescaled_counter: up/down counter over 0..MAX, stepping once per DIV enabled cycles, wrap or saturate at the ends.
module prescaled_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 2**WIDTH-1,
    parameter int DIV   = 1,
    parameter int SAT   = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);
    if (WIDTH < 1 || MAX < 1 || MAX > 2**WIDTH-1 || DIV < 1) begin : g_bad_cfg
        $error("prescaled_counter: illegal WIDTH/MAX/DIV configuration");
    end
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [WIDTH-1:0] W_MAX = WIDTH'(MAX);
    localparam logic [PW-1:0] P_LAST = PW'(DIV-1);
    logic [PW-1:0]    r_pre;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             w_step;
    logic             w_bnd;
    logic [WIDTH-1:0] w_next;
    always_comb begin
        w_step = r_pre == P_LAST;
        w_bnd  = i_up ? r_count == W_MAX : r_count == '0;
        // at a boundary: saturate holds, wrap jumps to the opposite end
        w_next = w_bnd ? (SAT != 0 ? r_count : (i_up ? '0 : W_MAX))
                       : (i_up ? r_count + WIDTH'(1) : r_count - WIDTH'(1));
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            r_pre   <= '0;
            r_tc    <= 1'b0;
        end else if (i_load) begin
            r_count <= i_data > W_MAX ? W_MAX : i_data;
            r_pre   <= '0;
            r_tc    <= 1'b0;
        end else if (i_en) begin
            r_pre   <= w_step ? '0 : r_pre + PW'(1);
            r_count <= w_step ? w_next : r_count;
            r_tc    <= w_step && w_bnd;
        end else begin
            r_tc    <= 1'b0;
        end
    end
    assign o_count = r_count;
    assign o_tc    = r_tc;
endmodule

// File: tb/tb_prescaled_counter.sv
// tb_prescaled_counter: four configurations driven in lockstep, checked against a reference model scoreboard and hand vectors.
module tb_prescaled_counter;
    logic clock = 1'b0;
    logic reset, en, up, ld;
    logic [3:0] data;
    logic [3:0] oc [4];
    logic       otc [4];
    int n_chk = 0;
    int n_err = 0;
    always #5 clock = ~clock;

    prescaled_counter #(.WIDTH(4), .MAX(15), .DIV(1), .SAT(0)) u_a (.clock(clock), .reset(reset), .i_en(en), .i_up(up), .i_load(ld), .i_data(data), .o_count(oc[0]), .o_tc(otc[0]));
    prescaled_counter #(.WIDTH(4), .MAX(9),  .DIV(1), .SAT(0)) u_b (.clock(clock), .reset(reset), .i_en(en), .i_up(up), .i_load(ld), .i_data(data), .o_count(oc[1]), .o_tc(otc[1]));
    prescaled_counter #(.WIDTH(4), .MAX(9),  .DIV(1), .SAT(1)) u_c (.clock(clock), .reset(reset), .i_en(en), .i_up(up), .i_load(ld), .i_data(data), .o_count(oc[2]), .o_tc(otc[2]));
    prescaled_counter #(.WIDTH(4), .MAX(9),  .DIV(3), .SAT(0)) u_d (.clock(clock), .reset(reset), .i_en(en), .i_up(up), .i_load(ld), .i_data(data), .o_count(oc[3]), .o_tc(otc[3]));

    typedef struct packed {
        logic [3:0][3:0] c;
        logic [3:0]      t;
    } exp_t;
    typedef struct {
        logic rst, en, up, ld;
        logic [3:0] data;
        int exp_c;
        int exp_t;
    } vec_t;

    exp_t q [$];
    int m_max [4] = '{15, 9, 9, 9};
    int m_div [4] = '{1, 1, 1, 3};
    int m_sat [4] = '{0, 0, 1, 0};
    int m_c [4];
    int m_p [4];
    int m_t [4];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                m_c[i] = 0; m_p[i] = 0; m_t[i] = 0;
            end else if (ld) begin
                m_c[i] = int'(data) > m_max[i] ? m_max[i] : int'(data);
                m_p[i] = 0; m_t[i] = 0;
            end else if (en) begin
                if (m_p[i] == m_div[i] - 1) begin
                    m_p[i] = 0;
                    if (up && m_c[i] == m_max[i]) begin
                        m_t[i] = 1; m_c[i] = m_sat[i] != 0 ? m_max[i] : 0;
                    end else if (!up && m_c[i] == 0) begin
                        m_t[i] = 1; m_c[i] = m_sat[i] != 0 ? 0 : m_max[i];
                    end else begin
                        m_t[i] = 0; m_c[i] = up ? m_c[i] + 1 : m_c[i] - 1;
                    end
                end else begin
                    m_p[i]++; m_t[i] = 0;
                end
            end else begin
                m_t[i] = 0;
            end
            e.c[i] = 4'(m_c[i]);
            e.t[i] = m_t[i] != 0;
        end
        q.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic e, input logic u, input logic l, input logic [3:0] d);
        exp_t x;
        @(negedge clock);
        reset = r; en = e; up = u; ld = l; data = d;
        model_step();
        @(posedge clock);
        #1;
        x = q.pop_front();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sb_count[%0d]", i), int'(oc[i]), int'(x.c[i]));
            chk($sformatf("sb_tc[%0d]", i), int'(otc[i]), int'(x.t[i]));
        end
    endtask

    vec_t tbl [12];
    int pulses [$];

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b1; ld = 1'b0; data = '0;
        tbl[0]  = '{0, 0, 1, 1, 4'd14, 14, 0};
        tbl[1]  = '{0, 1, 1, 0, 4'd0,  15, 0};
        tbl[2]  = '{0, 1, 1, 0, 4'd0,   0, 1};
        tbl[3]  = '{0, 1, 0, 0, 4'd0,  15, 1};
        tbl[4]  = '{0, 1, 0, 0, 4'd0,  14, 0};
        tbl[5]  = '{0, 0, 0, 0, 4'd0,  14, 0};
        tbl[6]  = '{0, 1, 1, 1, 4'd3,   3, 0};
        tbl[7]  = '{1, 1, 1, 1, 4'd7,   0, 0};
        tbl[8]  = '{0, 1, 0, 0, 4'd0,  15, 1};
        tbl[9]  = '{0, 0, 1, 1, 4'd15, 15, 0};
        tbl[10] = '{0, 1, 1, 0, 4'd0,   0, 1};
        tbl[11] = '{1, 0, 1, 0, 4'd0,   0, 0};

        cycle(1, 1, 1, 1, 4'd5);
        for (int i = 0; i < 4; i++) begin
            chk("reset_count", int'(oc[i]), 0);
            chk("reset_tc", int'(otc[i]), 0);
        end

        foreach (tbl[k]) begin
            cycle(tbl[k].rst, tbl[k].en, tbl[k].up, tbl[k].ld, tbl[k].data);
            chk($sformatf("vec%0d_count", k), int'(oc[0]), tbl[k].exp_c);
            chk($sformatf("vec%0d_tc", k), int'(otc[0]), tbl[k].exp_t);
        end

        // 50 up steps from reset on the full-range wrapping counter
        cycle(1, 0, 1, 0, 4'd0);
        for (int k = 1; k <= 50; k++) begin
            cycle(0, 1, 1, 0, 4'd0);
            if (otc[0]) pulses.push_back(k);
        end
        chk("wrap50_count", int'(oc[0]), 2);
        chk("wrap50_pulses", pulses.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("wrap50_pulse%0d", i), i < pulses.size() ? pulses[i] : -1, 16 * (i + 1));

        cycle(1, 0, 1, 0, 4'd0);
        cycle(0, 1, 0, 0, 4'd0);
        chk("down_at0_count", int'(oc[1]), 9);
        chk("down_at0_tc", int'(otc[1]), 1);
        cycle(0, 0, 0, 0, 4'd0);
        chk("down_at0_tc_clear", int'(otc[1]), 0);

        cycle(0, 0, 1, 1, 4'd8);
        cycle(0, 1, 1, 0, 4'd0);
        chk("sat_step1_count", int'(oc[2]), 9);
        chk("sat_step1_tc", int'(otc[2]), 0);
        cycle(0, 1, 1, 0, 4'd0);
        chk("sat_step2_count", int'(oc[2]), 9);
        chk("sat_step2_tc", int'(otc[2]), 1);
        cycle(0, 1, 1, 0, 4'd0);
        chk("sat_step3_count", int'(oc[2]), 9);
        chk("sat_step3_tc", int'(otc[2]), 1);

        cycle(1, 0, 1, 0, 4'd0);
        for (int k = 1; k <= 7; k++) begin
            cycle(0, 1, 1, 0, 4'd0);
            chk($sformatf("div3_c%0d", k), int'(oc[3]), k / 3);
        end
        cycle(0, 1, 1, 0, 4'd0);
        chk("div3_c8", int'(oc[3]), 2);
        cycle(0, 1, 1, 0, 4'd0);
        chk("div3_c9", int'(oc[3]), 3);

        cycle(0, 1, 1, 1, 4'd12);
        chk("load_clamp", int'(oc[1]), 9);
        chk("load_clamp_tc", int'(otc[1]), 0);
        cycle(1, 1, 1, 1, 4'd12);
        chk("reset_over_load", int'(oc[1]), 0);

        cycle(0, 1, 1, 0, 4'd0);
        cycle(0, 1, 1, 0, 4'd0);
        cycle(1, 1, 1, 0, 4'd0);
        for (int k = 1; k <= 3; k++) begin
            cycle(0, 1, 1, 0, 4'd0);
            chk($sformatf("div3_rst_c%0d", k), int'(oc[3]), k == 3 ? 1 : 0);
        end

        for (int k = 0; k < 300; k++)
            cycle($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0, 4'($urandom_range(0, 15)));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/prescaled_counter.md
PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, 4, counter width in bits.
REQ-003 Parameter MAX, 2**WIDTH-1, terminal value; count range 0..MAX inclusive.
REQ-004 Parameter DIV, 1, prescale ratio; one count step per DIV enabled cycles.
REQ-005 Parameter SAT, 0, boundary mode; 0 = wrap, 1 = saturate.
REQ-006 clock  input  1  chip clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 i_en  input  1  count enable; prescaler advances only while high.
REQ-009 i_up  input  1  direction; 1 = up, 0 = down.
REQ-010 i_load  input  1  synchronous load strobe.
REQ-011 i_data  input  WIDTH  load value.
REQ-012 o_count  output  WIDTH  registered count value.
REQ-013 o_tc  output  1  registered terminal-count pulse.

Function
REQ-014 The block SHALL reject at elaboration any configuration with WIDTH < 1, MAX < 1, MAX > 2**WIDTH-1 or DIV < 1.
REQ-015 The internal prescaler SHALL hold values 0..DIV-1, advancing by 1 on each cycle with i_en=1, i_load=0 and reset=0.
REQ-016 A step SHALL occur on a cycle with i_en=1, i_load=0, reset=0 and prescaler = DIV-1; on that edge the prescaler returns to 0.
REQ-017 With DIV=1 a step SHALL occur on every enabled cycle.
REQ-018 On an up step with count < MAX, count SHALL become count+1; on a down step with count > 0, count SHALL become count-1.
REQ-019 On an up step at MAX, count SHALL become 0 if SAT=0 and remain MAX if SAT=1.
REQ-020 On a down step at 0, count SHALL become MAX if SAT=0 and remain 0 if SAT=1.
REQ-021 o_tc SHALL be 1 for exactly the cycle after any step taken at a boundary (up at MAX, down at 0), in both modes; otherwise 0.
REQ-022 In saturate mode, each successive step attempted at a boundary SHALL produce its own o_tc pulse.
REQ-023 o_count SHALL reflect a step one cycle after the stepping edge (single-register latency, no combinational path from inputs).
REQ-024 i_load=1 SHALL set count to i_data, or to MAX when i_data > MAX, clear the prescaler and drive o_tc to 0 on the next cycle.
REQ-025 i_load SHALL take priority over i_en; no step occurs in a load cycle.
REQ-026 With i_en=0 and i_load=0, count and prescaler SHALL hold and o_tc SHALL be 0 on the next cycle.
REQ-027 A change of i_up between steps SHALL NOT clear the prescaler; the step direction is the value of i_up on the stepping cycle.
REQ-028 Arithmetic SHALL be performed modulo MAX+1 in WIDTH bits; count SHALL never exceed MAX.

Reset
REQ-029 reset=1 SHALL take priority over i_load and i_en.
REQ-030 On reset: o_count=0, prescaler=0, o_tc=0 on the following cycle.
REQ-031 Reset asserted mid-prescale SHALL discard partial progress; the first post-reset step requires DIV further enabled cycles.

Verification
REQ-032 WIDTH=4, MAX=15, DIV=1, SAT=0; reset, then i_en=1, i_up=1 for 50 cycles -> o_count=2; o_tc pulses exactly 3 times, following the 16th, 32nd and 48th steps.
REQ-033 MAX=9, SAT=0, count 0; one down step -> o_count=9, o_tc=1 for one cycle.
REQ-034 MAX=9, SAT=1; load 8, then 3 up steps -> o_count 9,9,9; o_tc=0 after the 1st step, 1 after the 2nd and after the 3rd.
REQ-035 DIV=3, from reset; i_en=1 for 7 cycles -> steps on cycles 3 and 6, o_count=2, prescaler=1.
REQ-036 MAX=9; i_load=1, i_en=1, i_data=12 -> o_count=9, no step; same cycle with reset=1 -> o_count=0.
REQ-037 DIV=3; 2 enabled cycles, reset, then enabled cycles -> o_count stays 0 until the 3rd enabled cycle after reset, then 1.
